coeff_loader: RTL and testbench

// Upstream configuration stage for the lookahead IIR filter. Receives the nine filter

---
 rtl/coeff_loader.sv | 194 +++++++++++++++++++
 tb/tb_coeff_loader.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coeff_loader.sv
// coeff_loader: assembles the nine lookahead-IIR coefficients (b0..b6, a3, a6)
// from a stream of narrow words into a shadow bank. When the load is complete,
// the block commits the whole set to the active bank in a single cycle.
// Optional feature macro: COEFF_CHECKSUM_EN. When defined, the block expects one
// extra word after the coefficients. That word must equal the XOR of all
// coefficient words, otherwise the load is rejected.

module coeff_loader #(
  parameter int WIDTH      = 64,
  parameter int WORD_BITS  = 16,
  parameter int NUM_COEFFS = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_start,
  input  logic [WORD_BITS-1:0] word_in,
  input  logic                 word_valid,
  output logic                 word_ready,
  output logic [WIDTH-1:0]     b0,
  output logic [WIDTH-1:0]     b1,
  output logic [WIDTH-1:0]     b2,
  output logic [WIDTH-1:0]     b3,
  output logic [WIDTH-1:0]     b4,
  output logic [WIDTH-1:0]     b5,
  output logic [WIDTH-1:0]     b6,
  output logic [WIDTH-1:0]     a3,
  output logic [WIDTH-1:0]     a6,
  output logic                 coefficients_ready,
  output logic                 busy,
  output logic                 load_error
);

  // Words per coefficient and total words per load.
  localparam int WPC    = WIDTH / WORD_BITS;
  localparam int TW     = NUM_COEFFS * WPC;
  localparam int BANK_W = NUM_COEFFS * WIDTH;
  localparam int CNT_W  = $clog2(TW + 1);
  localparam int BASE_W = $clog2(BANK_W);

  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(TW - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_CHECK  = 3'd2;
  localparam logic [2:0] ST_COMMIT = 3'd3;
  localparam logic [2:0] ST_FLUSH  = 3'd4;

  logic [2:0]        state_q,  state_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [BANK_W-1:0] shadow_q, shadow_d;
  logic [BANK_W-1:0] active_q, active_d;
  logic              ready_q,  ready_d;
  logic              busy_q,   busy_d;
`ifdef COEFF_CHECKSUM_EN
  logic [WORD_BITS-1:0] xor_q, xor_d;
  logic                 err_q, err_d;
`endif

  logic              transfer;
  logic [BASE_W-1:0] word_base;

  // Words are accepted only while a load is collecting data. A load_start
  // pulse blocks acceptance so that the restart cycle never takes a word.
  always_comb begin
    word_ready = ((state_q == ST_LOAD) || (state_q == ST_CHECK)) && !load_start;
  end

  // The banks are flat vectors with b0 in the least significant slot. Word k
  // therefore lands at bit k*WORD_BITS, which is the same as coefficient k/WPC,
  // sub-word k%WPC.
  always_comb begin
    transfer  = word_valid && word_ready;
    word_base = BASE_W'(cnt_q) * BASE_W'(WORD_BITS);
  end

  // Next-state logic for the load sequencer. The COMMIT state copies the
  // shadow bank and drops ready. The FLUSH state raises ready one cycle later,
  // so the filter sees exactly one low cycle aligned with the new set.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    active_d = active_q;
    ready_d  = ready_q;
`ifdef COEFF_CHECKSUM_EN
    xor_d    = xor_q;
    err_d    = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
`ifdef COEFF_CHECKSUM_EN
          xor_d   = '0;
          err_d   = 1'b0;
`endif
        end
      end
      ST_LOAD: begin
        if (load_start) begin
          cnt_d = '0;
`ifdef COEFF_CHECKSUM_EN
          xor_d = '0;
`endif
        end else if (transfer) begin
          shadow_d[word_base +: WORD_BITS] = word_in;
          cnt_d = cnt_q + CNT_W'(1);
`ifdef COEFF_CHECKSUM_EN
          xor_d = xor_q ^ word_in;
          if (cnt_q == LAST_WORD) state_d = ST_CHECK;
`else
          if (cnt_q == LAST_WORD) state_d = ST_COMMIT;
`endif
        end
      end
`ifdef COEFF_CHECKSUM_EN
      ST_CHECK: begin
        if (load_start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
          xor_d   = '0;
        end else if (transfer) begin
          if (word_in == xor_q) begin
            state_d = ST_COMMIT;
          end else begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end
        end
      end
`endif
      ST_COMMIT: begin
        active_d = shadow_q;
        ready_d  = 1'b0;
        state_d  = ST_FLUSH;
      end
      ST_FLUSH: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State, banks and status flags; reset returns everything to an empty loader.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
`ifdef COEFF_CHECKSUM_EN
      xor_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
`ifdef COEFF_CHECKSUM_EN
      xor_q    <= xor_d;
      err_q    <= err_d;
`endif
    end
  end

  assign b0 = active_q[0*WIDTH +: WIDTH];
  assign b1 = active_q[1*WIDTH +: WIDTH];
  assign b2 = active_q[2*WIDTH +: WIDTH];
  assign b3 = active_q[3*WIDTH +: WIDTH];
  assign b4 = active_q[4*WIDTH +: WIDTH];
  assign b5 = active_q[5*WIDTH +: WIDTH];
  assign b6 = active_q[6*WIDTH +: WIDTH];
  assign a3 = active_q[7*WIDTH +: WIDTH];
  assign a6 = active_q[8*WIDTH +: WIDTH];

  assign coefficients_ready = ready_q;
  assign busy               = busy_q;
`ifdef COEFF_CHECKSUM_EN
  assign load_error = err_q;
`else
  assign load_error = 1'b0;
`endif

endmodule

// File: tb/tb_coeff_loader.sv
// tb_coeff_loader: directed tests for coeff_loader. These cover reset, a plain
// load, a load with gaps, restart, the checksum feature (when compiled in),
// reset in the middle of a load, and a load_start pulse during commit.

module tb_coeff_loader;

  localparam int WB     = 16;
  localparam int TW     = 36;
  localparam int BANK_W = 576;
`ifdef COEFF_CHECKSUM_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic          clk;
  logic          reset;
  logic          load_start;
  logic [WB-1:0] word_in;
  logic          word_valid;
  logic          word_ready;
  logic [63:0]   b0, b1, b2, b3, b4, b5, b6, a3, a6;
  logic          coefficients_ready;
  logic          busy;
  logic          load_error;

  logic [BANK_W-1:0] bank_out;

  int checks;
  int failures;

  logic [WB-1:0]     fresh_words [TW];
  logic [BANK_W-1:0] model_active;
  logic [BANK_W-1:0] model_new;

  int   busy_cycles;
  int   low_cycles;
  int   hold_bad;
  int   low_bad;
  int   first_ready_tick;
  int   tick_no;
  bit   timed_out;
  logic wr_at_restart;
  logic wr_at_commit;

  coeff_loader dut (
    .clk                (clk),
    .reset              (reset),
    .load_start         (load_start),
    .word_in            (word_in),
    .word_valid         (word_valid),
    .word_ready         (word_ready),
    .b0                 (b0),
    .b1                 (b1),
    .b2                 (b2),
    .b3                 (b3),
    .b4                 (b4),
    .b5                 (b5),
    .b6                 (b6),
    .a3                 (a3),
    .a6                 (a6),
    .coefficients_ready (coefficients_ready),
    .busy               (busy),
    .load_error         (load_error)
  );

  assign bank_out = {a6, a3, b6, b5, b4, b3, b2, b1, b0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected active bank for the current fresh_words set (word k at bit k*16).
  function automatic logic [BANK_W-1:0] build_bank();
    logic [BANK_W-1:0] r;
    r = '0;
    for (int k = 0; k < TW; k++) r[k*WB +: WB] = fresh_words[k];
    return r;
  endfunction

  function automatic logic [WB-1:0] fresh_xor();
    logic [WB-1:0] x;
    x = '0;
    for (int k = 0; k < TW; k++) x = x ^ fresh_words[k];
    return x;
  endfunction

  // One clock edge, then record what the outputs show after it.
  task automatic tick_obs();
    @(posedge clk);
    #1;
    tick_no++;
    if (busy) busy_cycles++;
    if (coefficients_ready) begin
      if (first_ready_tick < 0) first_ready_tick = tick_no;
      if (low_cycles == 0) begin
        if (bank_out !== model_active) hold_bad++;
      end else begin
        if (bank_out !== model_new) hold_bad++;
      end
    end else begin
      low_cycles++;
      if (bank_out !== model_new) low_bad++;
    end
  endtask

  task automatic send_word(input int max_gap, input logic [WB-1:0] value);
    int g;
    if (max_gap > 0) begin
      g = $urandom_range(max_gap, 1);
      word_valid = 1'b0;
      repeat (g) tick_obs();
    end
    word_valid = 1'b1;
    word_in    = value;
    tick_obs();
  endtask

  // Full load sequence: start pulse, optional restart, fresh words, checksum
  // word when the feature is built in, optional pulse in COMMIT, then drain.
  // cks_mode 1 sends the correct checksum, and 2 sends it with bit 0 flipped.
  task automatic run_load(input int max_gap, input int restart_after,
                          input bit pulse_commit, input int cks_mode);
    logic [WB-1:0] cks;
    busy_cycles      = 0;
    low_cycles       = 0;
    hold_bad         = 0;
    low_bad          = 0;
    first_ready_tick = -1;
    tick_no          = 0;
    timed_out        = 1'b0;
    wr_at_restart    = 1'b1;
    wr_at_commit     = 1'b1;
    model_new        = build_bank();
    cks              = fresh_xor();
    if (cks_mode == 2) cks = cks ^ 16'h0001;
    load_start = 1'b1;
    word_valid = 1'b0;
    tick_obs();
    load_start = 1'b0;
    if (restart_after >= 0) begin
      for (int k = 0; k <= restart_after; k++)
        send_word(max_gap, 16'hBEEF ^ WB'(k));
      load_start = 1'b1;
      word_valid = 1'b1;
      word_in    = 16'hDEAD;
      #1;
      wr_at_restart = word_ready;
      tick_obs();
      load_start = 1'b0;
      word_valid = 1'b0;
    end
    for (int k = 0; k < TW; k++) send_word(max_gap, fresh_words[k]);
`ifdef COEFF_CHECKSUM_EN
    send_word(max_gap, cks);
`endif
    word_valid = 1'b0;
    word_in    = '0;
    if (pulse_commit) begin
      load_start = 1'b1;
      #1;
      wr_at_commit = word_ready;
      tick_obs();
      load_start = 1'b0;
    end
    for (int i = 0; i < 10 && busy; i++) tick_obs();
    if (busy) timed_out = 1'b1;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    load_start = 1'b0;
    word_valid = 1'b0;
    word_in    = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    model_active = '0;
    model_new    = '0;
    checks++; if (bank_out !== '0) begin failures++; $display("[TB] FAIL reset_bank: got %0h expected 0", bank_out); end
    checks++; if (coefficients_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready: got %b expected 0", coefficients_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (load_error !== 1'b0) begin failures++; $display("[TB] FAIL reset_error: got %b expected 0", load_error); end
    checks++; if (word_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_word_ready: got %b expected 0", word_ready); end
  endtask

  task automatic test_basic_load();
    for (int k = 0; k < TW; k++) fresh_words[k] = WB'(k);
    run_load(0, -1, 1'b0, 1);
    checks++; if (timed_out !== 1'b0) begin failures++; $display("[TB] FAIL basic_timeout: busy still %b after drain budget, expected 0", busy); end
    checks++; if (busy_cycles !== 38 + EXTRA) begin failures++; $display("[TB] FAIL basic_busy_cycles: got %0d expected %0d", busy_cycles, 38 + EXTRA); end
    checks++; if (first_ready_tick !== 39 + EXTRA) begin failures++; $display("[TB] FAIL basic_ready_rise: got edge %0d expected %0d", first_ready_tick, 39 + EXTRA); end
    checks++; if (b0 !== 64'h0003_0002_0001_0000) begin failures++; $display("[TB] FAIL basic_b0: got %h expected 0003000200010000", b0); end
    checks++; if (a6 !== 64'h0023_0022_0021_0020) begin failures++; $display("[TB] FAIL basic_a6: got %h expected 0023002200210020", a6); end
    checks++; if (bank_out !== model_new) begin failures++; $display("[TB] FAIL basic_bank: got %0h expected %0h", bank_out, model_new); end
    checks++; if (coefficients_ready !== 1'b1) begin failures++; $display("[TB] FAIL basic_ready: got %b expected 1", coefficients_ready); end
    checks++; if (load_error !== 1'b0) begin failures++; $display("[TB] FAIL basic_error: got %b expected 0", load_error); end
    model_active = model_new;
  endtask

  task automatic test_gapped_load();
    for (int k = 0; k < TW; k++) fresh_words[k] = 16'h5A00 + WB'(k * 37);
    run_load(3, -1, 1'b0, 1);
    checks++; if (timed_out !== 1'b0) begin failures++; $display("[TB] FAIL gap_timeout: busy still %b, expected 0", busy); end
    checks++; if (hold_bad !== 0) begin failures++; $display("[TB] FAIL gap_hold: %0d cycles with wrong bank while ready, expected 0", hold_bad); end
    checks++; if (low_cycles !== 1) begin failures++; $display("[TB] FAIL gap_low_cycles: got %0d expected 1", low_cycles); end
    checks++; if (low_bad !== 0) begin failures++; $display("[TB] FAIL gap_low_bank: %0d low cycles without new bank, expected 0", low_bad); end
    checks++; if (bank_out !== model_new) begin failures++; $display("[TB] FAIL gap_bank: got %0h expected %0h", bank_out, model_new); end
    model_active = model_new;
  endtask

  task automatic test_restart();
    for (int k = 0; k < TW; k++) fresh_words[k] = 16'hC300 ^ WB'(k * 5 + 1);
    run_load(0, 17, 1'b0, 1);
    checks++; if (wr_at_restart !== 1'b0) begin failures++; $display("[TB] FAIL restart_word_ready: got %b expected 0", wr_at_restart); end
    checks++; if (timed_out !== 1'b0) begin failures++; $display("[TB] FAIL restart_timeout: busy still %b, expected 0", busy); end
    checks++; if (hold_bad !== 0) begin failures++; $display("[TB] FAIL restart_hold: %0d bad cycles, expected 0", hold_bad); end
    checks++; if (low_cycles !== 1) begin failures++; $display("[TB] FAIL restart_low_cycles: got %0d expected 1", low_cycles); end
    checks++; if (bank_out !== model_new) begin failures++; $display("[TB] FAIL restart_bank: got %0h expected %0h", bank_out, model_new); end
    model_active = model_new;
  endtask

`ifdef COEFF_CHECKSUM_EN
  task automatic test_checksum();
    for (int k = 0; k < TW; k++) fresh_words[k] = 16'h7100 + WB'(k * 3);
    run_load(0, -1, 1'b0, 2);
    checks++; if (load_error !== 1'b1) begin failures++; $display("[TB] FAIL cks_error_set: got %b expected 1", load_error); end
    checks++; if (bank_out !== model_active) begin failures++; $display("[TB] FAIL cks_bank_kept: got %0h expected %0h", bank_out, model_active); end
    checks++; if (coefficients_ready !== 1'b1) begin failures++; $display("[TB] FAIL cks_ready_kept: got %b expected 1", coefficients_ready); end
    checks++; if (low_cycles !== 0) begin failures++; $display("[TB] FAIL cks_no_low: got %0d expected 0", low_cycles); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL cks_busy: got %b expected 0", busy); end
    run_load(0, -1, 1'b0, 1);
    checks++; if (load_error !== 1'b0) begin failures++; $display("[TB] FAIL cks_error_clear: got %b expected 0", load_error); end
    checks++; if (bank_out !== model_new) begin failures++; $display("[TB] FAIL cks_retry_bank: got %0h expected %0h", bank_out, model_new); end
    checks++; if (low_cycles !== 1) begin failures++; $display("[TB] FAIL cks_retry_low: got %0d expected 1", low_cycles); end
    model_active = model_new;
  endtask
`endif

  task automatic test_reset_midload();
    for (int k = 0; k < TW; k++) fresh_words[k] = 16'h0F00 + WB'(k);
    load_start = 1'b1;
    tick_obs();
    load_start = 1'b0;
    for (int k = 0; k < 20; k++) send_word(0, fresh_words[k]);
    word_valid = 1'b1;
    word_in    = fresh_words[20];
    reset      = 1'b1;
    @(posedge clk);
    #1;
    reset      = 1'b0;
    word_valid = 1'b0;
    word_in    = '0;
    checks++; if (bank_out !== '0) begin failures++; $display("[TB] FAIL midreset_bank: got %0h expected 0", bank_out); end
    checks++; if (coefficients_ready !== 1'b0) begin failures++; $display("[TB] FAIL midreset_ready: got %b expected 0", coefficients_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midreset_busy: got %b expected 0", busy); end
    checks++; if (word_ready !== 1'b0) begin failures++; $display("[TB] FAIL midreset_word_ready: got %b expected 0", word_ready); end
    model_active = '0;
    run_load(0, -1, 1'b0, 1);
    checks++; if (timed_out !== 1'b0) begin failures++; $display("[TB] FAIL midreset_timeout: busy still %b, expected 0", busy); end
    checks++; if (busy_cycles !== 38 + EXTRA) begin failures++; $display("[TB] FAIL midreset_busy_cycles: got %0d expected %0d", busy_cycles, 38 + EXTRA); end
    checks++; if (bank_out !== model_new) begin failures++; $display("[TB] FAIL midreset_bank_after: got %0h expected %0h", bank_out, model_new); end
    checks++; if (coefficients_ready !== 1'b1) begin failures++; $display("[TB] FAIL midreset_ready_after: got %b expected 1", coefficients_ready); end
    model_active = model_new;
  endtask

  task automatic test_commit_pulse();
    for (int k = 0; k < TW; k++) fresh_words[k] = 16'hA5A5 ^ WB'(k << 4);
    run_load(0, -1, 1'b1, 1);
    checks++; if (wr_at_commit !== 1'b0) begin failures++; $display("[TB] FAIL commit_word_ready: got %b expected 0", wr_at_commit); end
    checks++; if (timed_out !== 1'b0) begin failures++; $display("[TB] FAIL commit_timeout: busy still %b, expected 0", busy); end
    checks++; if (busy_cycles !== 38 + EXTRA) begin failures++; $display("[TB] FAIL commit_busy_cycles: got %0d expected %0d", busy_cycles, 38 + EXTRA); end
    checks++; if (low_cycles !== 1) begin failures++; $display("[TB] FAIL commit_low_cycles: got %0d expected 1", low_cycles); end
    checks++; if (bank_out !== model_new) begin failures++; $display("[TB] FAIL commit_bank: got %0h expected %0h", bank_out, model_new); end
    model_active = model_new;
    repeat (3) tick_obs();
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL commit_stays_idle: busy got %b expected 0", busy); end
    checks++; if (word_ready !== 1'b0) begin failures++; $display("[TB] FAIL commit_idle_word_ready: got %b expected 0", word_ready); end
    checks++; if (coefficients_ready !== 1'b1) begin failures++; $display("[TB] FAIL commit_ready_held: got %b expected 1", coefficients_ready); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic_load();
    test_gapped_load();
    test_restart();
`ifdef COEFF_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_midload();
    test_commit_pulse();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
